// File: rtl/ecc_pkg.sv
// Shared definitions for the ECC scrubber: FSM state type, width defaults and
// the check-bit column generator used by the encoder.
package ecc_pkg;

   localparam int unsigned DAT_WIDTH_DEF  = 128;
   localparam int unsigned ECC_WIDTH_DEF  = 9;
   localparam int unsigned COL_MIN_WEIGHT = 3;

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_WAIT,
      ST_REQ,
      ST_RESP,
      ST_CHECK
   } scrub_state_t;

   // Column for data bit idx: the idx-th value (ascending) of odd weight >= 3,
   // so single-bit data and check-bit errors give distinct syndromes.
   function automatic logic [31:0] ecc_col(input int unsigned idx, input int unsigned width);
      logic [31:0] col;
      int unsigned n;
      int unsigned v;
      logic        found;
      col   = '0;
      n     = 0;
      v     = 0;
      found = 1'b0;
      while (!found && v < (32'd1 << width)) begin
         if ($countones(v) >= COL_MIN_WEIGHT && ($countones(v) % 2) == 1) begin
            if (n == idx) begin
               col   = v;
               found = 1'b1;
            end
            n++;
         end
         v++;
      end
      return col;
   endfunction

endpackage

// File: rtl/ecc_encoder.sv
// Combinational check-bit generator: XOR of the fixed column pattern of every
// set data bit.
module ecc_encoder
   import ecc_pkg::*;
#(
   parameter int unsigned DAT_WIDTH = DAT_WIDTH_DEF,
   parameter int unsigned ECC_WIDTH = ECC_WIDTH_DEF
) (
   input  logic [DAT_WIDTH-1:0] data,
   output logic [ECC_WIDTH-1:0] ecc
);

   logic [ECC_WIDTH-1:0] term [DAT_WIDTH];

   for (genvar i = 0; i < DAT_WIDTH; i++) begin : g_col
      localparam logic [ECC_WIDTH-1:0] COL = ECC_WIDTH'(ecc_col(i, ECC_WIDTH));
      assign term[i] = data[i] ? COL : '0;
   end

   always_comb begin
      ecc = '0;
      for (int unsigned i = 0; i < DAT_WIDTH; i++) begin
         ecc = ecc ^ term[i];
      end
   end

endmodule

// File: rtl/ecc_scrub_ctrl.sv
// Background ECC scrubber: walks the memory one read at a time through the
// arbiter, recomputes check bits of each word and reports mismatches.
module ecc_scrub_ctrl
   import ecc_pkg::*;
#(
   parameter int unsigned DAT_WIDTH  = DAT_WIDTH_DEF,
   parameter int unsigned ECC_WIDTH  = ECC_WIDTH_DEF,
   parameter int unsigned DEPTH      = 1024,
   parameter int unsigned ADDR_WIDTH = $clog2(DEPTH),
   parameter int unsigned CNT_WIDTH  = 16,
   parameter int unsigned IVL_WIDTH  = 16
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  scrub_en,
   input  logic [IVL_WIDTH-1:0]  interval,
   input  logic                  clr_count,
   output logic                  mem_req,
   output logic [ADDR_WIDTH-1:0] mem_addr,
   input  logic                  mem_gnt,
   input  logic                  mem_rvalid,
   input  logic [DAT_WIDTH-1:0]  mem_rdata,
   input  logic [ECC_WIDTH-1:0]  mem_recc,
   output logic                  busy,
   output logic                  err_valid,
   output logic [ADDR_WIDTH-1:0] err_addr,
   output logic [ECC_WIDTH-1:0]  err_syndrome,
   output logic [CNT_WIDTH-1:0]  err_count,
   output logic                  pass_done
);

   scrub_state_t          state, state_nxt;
   logic [IVL_WIDTH-1:0]  ivl_cnt;
   logic [ADDR_WIDTH-1:0] scrub_addr;
   logic [DAT_WIDTH-1:0]  data_q;
   logic [ECC_WIDTH-1:0]  recc_q;
   logic [ECC_WIDTH-1:0]  ecc_calc;
   logic [ECC_WIDTH-1:0]  syndrome;
   logic                  mismatch;
   logic                  last_addr;
   logic                  wait_entry;
   logic                  capture;
   logic                  checking;
   logic                  err_inc;

   ecc_encoder #(
      .DAT_WIDTH (DAT_WIDTH),
      .ECC_WIDTH (ECC_WIDTH)
   ) u_encoder (
      .data (data_q),
      .ecc  (ecc_calc)
   );

   assign syndrome  = ecc_calc ^ recc_q;
   assign mismatch  = |syndrome;
   assign last_addr = (scrub_addr == ADDR_WIDTH'(DEPTH - 1));
   assign mem_addr  = scrub_addr;
   assign err_inc   = checking && mismatch;

   always_ff @(posedge clk) begin
      if (rst) begin
         state <= ST_IDLE;
      end else begin
         state <= state_nxt;
      end
   end

   // Once a request is raised the read always runs to completion; scrub_en
   // is only honoured in IDLE, WAIT and on leaving CHECK.
   always_comb begin
      state_nxt = state;
      unique case (state)
         ST_IDLE:  if (scrub_en) state_nxt = ST_WAIT;
         ST_WAIT: begin
            if (!scrub_en) begin
               state_nxt = ST_IDLE;
            end else if (ivl_cnt == '0) begin
               state_nxt = ST_REQ;
            end
         end
         ST_REQ:   if (mem_gnt) state_nxt = ST_RESP;
         ST_RESP:  if (mem_rvalid) state_nxt = ST_CHECK;
         ST_CHECK: state_nxt = scrub_en ? ST_WAIT : ST_IDLE;
         default:  state_nxt = ST_IDLE;
      endcase
   end

   always_comb begin
      mem_req    = (state == ST_REQ);
      busy       = (state != ST_IDLE);
      wait_entry = (state_nxt == ST_WAIT) && (state != ST_WAIT);
      capture    = (state == ST_RESP) && mem_rvalid;
      checking   = (state == ST_CHECK);
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         ivl_cnt      <= '0;
         scrub_addr   <= '0;
         data_q       <= '0;
         recc_q       <= '0;
         err_valid    <= 1'b0;
         err_addr     <= '0;
         err_syndrome <= '0;
         err_count    <= '0;
         pass_done    <= 1'b0;
      end else begin
         err_valid <= 1'b0;
         pass_done <= 1'b0;

         if (wait_entry) begin
            ivl_cnt <= interval;
         end else if (state == ST_WAIT && ivl_cnt != '0) begin
            ivl_cnt <= ivl_cnt - IVL_WIDTH'(1);
         end

         if (capture) begin
            data_q <= mem_rdata;
            recc_q <= mem_recc;
         end

         if (checking) begin
            scrub_addr <= last_addr ? '0 : scrub_addr + ADDR_WIDTH'(1);
            pass_done  <= last_addr;
            if (mismatch) begin
               err_valid    <= 1'b1;
               err_addr     <= scrub_addr;
               err_syndrome <= syndrome;
            end
         end

         // A clear coinciding with a new mismatch keeps that mismatch counted.
         if (clr_count) begin
            err_count <= err_inc ? CNT_WIDTH'(1) : '0;
         end else if (err_inc && err_count != '1) begin
            err_count <= err_count + CNT_WIDTH'(1);
         end
      end
   end

endmodule
